// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the two-requester UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ABORT     = 3'd5
    } arb_state_e;

    localparam logic [31:0] CTRL_SEND       = 32'h0000_0001;
    localparam logic [31:0] CTRL_STOP       = 32'h0000_0000;
    localparam int          TIMEOUT_DEFAULT = 16384;

    function automatic logic [31:0] byte_word(input logic [7:0] b);
        return {24'h0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb_if
// Description : Requester handshake and UART register-write bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arb_if;

    logic [1:0]  req_valid_i;
    logic [7:0]  req_data0_i;
    logic [7:0]  req_data1_i;
    logic [1:0]  req_ready_o;
    logic [31:0] uart_data_o;
    logic        uart_we_data_o;
    logic        uart_we_ctrl_o;
    logic        uart_busy_i;

    // slave: the arbiter side
    modport slave (
        input  req_valid_i, req_data0_i, req_data1_i, uart_busy_i,
        output req_ready_o, uart_data_o, uart_we_data_o, uart_we_ctrl_o
    );

    // master: requesters plus UART peripheral
    modport master (
        output req_valid_i, req_data0_i, req_data1_i, uart_busy_i,
        input  req_ready_o, uart_data_o, uart_we_data_o, uart_we_ctrl_o
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter, registered pointer, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    input  wire logic [1:0] i_req,
    output logic      [1:0] o_grant
);

    logic       r_ptr;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // After a grant the pointer favours the requester that lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|w_grant) begin
            r_ptr <= w_grant[0];
        end
    end

    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Arbitrates two byte requesters onto a UART register interface.
//               Optional wait timeout with ABORT: define UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int NREQ           = 2
) (
    input  wire logic      clk_i,
    input  wire logic      reset_i,
    uart_tx_arb_if.slave   bus,
    output logic           busy_o,
    output logic           err_o
);

    localparam logic [2:0] c_IDLE      = ST_IDLE;
    localparam logic [2:0] c_LOAD      = ST_LOAD;
    localparam logic [2:0] c_START     = ST_START;
    localparam logic [2:0] c_WAIT_BUSY = ST_WAIT_BUSY;
    localparam logic [2:0] c_WAIT_DONE = ST_WAIT_DONE;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [7:0]      r_byte;
    logic            r_busy;
    logic [NREQ-1:0] w_grant;
    logic            w_en;
    logic [31:0]     w_data;
    logic            w_we_data;
    logic            w_we_ctrl;

    // Reset also blocks the handshake so no byte is accepted while it is asserted
    assign w_en = (r_state == c_IDLE) && !bus.uart_busy_i && !reset_i;

    rr_arb2 u_arb (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_en    (w_en),
        .i_req   (bus.req_valid_i),
        .o_grant (w_grant)
    );

    assign bus.req_ready_o = w_grant;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [2:0] c_ABORT = ST_ABORT;
    localparam int         c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic               w_timeout;

    assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == c_START) begin
                r_cnt <= '0;
            end else if ((r_state == c_WAIT_BUSY) || (r_state == c_WAIT_DONE)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_next == c_ABORT) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign err_o        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (|w_grant) w_next = c_LOAD;
            c_LOAD:      w_next = c_START;
            c_START:     w_next = c_WAIT_BUSY;
            c_WAIT_BUSY: begin
                if (bus.uart_busy_i) w_next = c_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                if (w_timeout) w_next = c_ABORT;
`endif
            end
            c_WAIT_DONE: begin
                if (!bus.uart_busy_i) w_next = c_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                if (w_timeout) w_next = c_ABORT;
`endif
            end
`ifdef UART_ARB_TIMEOUT_EN
            c_ABORT:     w_next = c_IDLE;
`endif
            default:     w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != c_IDLE);
            if (|w_grant) begin
                r_byte <= w_grant[1] ? bus.req_data1_i : bus.req_data0_i;
            end
        end
    end

    always_comb begin
        w_data    = 32'h0;
        w_we_data = 1'b0;
        w_we_ctrl = 1'b0;
        case (r_state)
            c_LOAD: begin
                w_we_data = 1'b1;
                w_data    = byte_word(r_byte);
            end
            c_START: begin
                w_we_ctrl = 1'b1;
                w_data    = CTRL_SEND;
            end
`ifdef UART_ARB_TIMEOUT_EN
            c_ABORT: begin
                w_we_ctrl = 1'b1;
                w_data    = CTRL_STOP;
            end
`endif
            default: begin
                w_data    = 32'h0;
            end
        endcase
    end

    assign bus.uart_data_o    = w_data;
    assign bus.uart_we_data_o = w_we_data;
    assign bus.uart_we_ctrl_o = w_we_ctrl;
    assign busy_o             = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16384, maximum cycles spent waiting on the UART before abort (used only with the timeout feature).
REQ-002 Parameter NREQ, 2, number of requesters; fixed at 2 for this revision.
REQ-003 Port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset_i  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid_i  input  2  per-requester byte-valid.
REQ-006 Port req_data0_i  input  8  byte from requester 0.
REQ-007 Port req_data1_i  input  8  byte from requester 1.
REQ-008 Port req_ready_o  output  2  per-requester accept strobe, one-hot or zero.
REQ-009 Port uart_data_o  output  32  write data to the UART peripheral.
REQ-010 Port uart_we_data_o  output  1  UART data-register write enable.
REQ-011 Port uart_we_ctrl_o  output  1  UART control-register write enable.
REQ-012 Port uart_busy_i  input  1  UART control bit0 readback; high while a frame is in flight.
REQ-013 Port busy_o  output  1  arbiter not in IDLE.
REQ-014 Port err_o  output  1  sticky timeout flag; tied 0 when the timeout feature is absent.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, and ABORT (ABORT exists only with the timeout feature).
REQ-016 In IDLE, with uart_busy_i low and at least one req_valid_i bit set, the arbiter SHALL raise exactly one req_ready_o bit for one cycle, capture that requester's byte, and go to LOAD.
REQ-017 Grant rule: a single valid requester SHALL win; if both are valid, the round-robin pointer SHALL decide; after a grant the pointer SHALL point to the other requester.
REQ-018 A transfer SHALL occur only in the cycle where valid and ready are both high; requesters SHALL hold data stable while valid is high.
REQ-019 LOAD: uart_we_data_o=1 and uart_data_o={24'h0,byte} for exactly one cycle, then go to START.
REQ-020 START: uart_we_ctrl_o=1 and uart_data_o=32'h0000_0001 for exactly one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY: when uart_busy_i is high, go to WAIT_DONE.
REQ-022 WAIT_DONE: when uart_busy_i is low, go to IDLE; the next grant is allowed no earlier than the following cycle.
REQ-023 Outside LOAD and START, uart_we_data_o and uart_we_ctrl_o SHALL be 0 and uart_data_o SHALL be 32'h0.
REQ-024 Latency: the grant cycle is G, the data write is at G+1, and the control write is at G+2.
REQ-025 While uart_busy_i is high in IDLE (the UART was started externally), no grant SHALL be issued.
REQ-026 busy_o SHALL be 1 in every state except IDLE, and registered with the state.

Reset
REQ-027 On reset_i high at a clock edge: state=IDLE, pointer=requester 0, req_ready_o=0, uart_we_*_o=0, uart_data_o=0, busy_o=0, err_o=0, timeout counter=0.
REQ-028 Reset during any state SHALL abandon the byte; the arbiter SHALL not issue another UART write until a new grant.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN present: a counter SHALL clear on entry to WAIT_BUSY and count in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES-1 it SHALL go to ABORT, which sets err_o, writes control 32'h0 (uart_we_ctrl_o=1) for one cycle, then returns to IDLE.
REQ-030 Macro absent: no counter and no ABORT state; err_o SHALL be constant 0; WAIT states SHALL wait indefinitely.
REQ-031 err_o SHALL clear only on reset.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the state enum, CTRL_SEND=32'h1, CTRL_STOP=32'h0, and TIMEOUT_DEFAULT=16384.
REQ-033 Grant selection and pointer update SHALL live in sub-module rr_arb2 (2-way round-robin arbiter, registered pointer, combinational one-hot grant).

Verification
REQ-034 Req0 valid with 8'h55 and the UART model asserts busy 2 cycles after the control write -> ready0 at G; we_data with 32'h55 at G+1; we_ctrl with 32'h1 at G+2; busy_o high until busy falls.
REQ-035 Req0=8'hA5 and req1=8'h3C both valid after reset -> 8'hA5 sent first, then 8'h3C; ready bits never high together.
REQ-036 Req0 held valid continuously while req1 pulses valid once -> grants strictly alternate 0,1,0.
REQ-037 reset_i asserted in WAIT_DONE -> all outputs zero the next cycle, pointer=0, and no further writes until a new request.
REQ-038 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, the UART model never asserts busy -> ABORT after 64 cycles in WAIT_BUSY, a control write of 32'h0, err_o=1, and the next request is still served.
REQ-039 uart_busy_i held high in IDLE while req1 is valid -> no ready until busy drops, then grant within 1 cycle.
